// File: rtl/wshb_tester_pkg.sv
// rtl/wshb_tester_pkg.sv - shared types and LFSR step function for the Wishbone memory tester
package wshb_tester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_REQ = 2'd1,
    ST_RD_REQ = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_ADDR  = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_NADDR = 2'd3
  } mode_t;

  // Fibonacci XOR LFSR, maximal-length taps per data width; result masked to dw bits.
  function automatic logic [63:0] lfsr_next(input logic [63:0] v, input int unsigned dw);
    logic        fb;
    logic [63:0] mask;
    case (dw)
      32'd8:   fb = v[7] ^ v[5] ^ v[4] ^ v[3];
      32'd16:  fb = v[15] ^ v[14] ^ v[12] ^ v[3];
      32'd32:  fb = v[31] ^ v[21] ^ v[1] ^ v[0];
      default: fb = v[63] ^ v[62] ^ v[60] ^ v[59];
    endcase
    mask = {64{1'b1}} >> (32'd64 - dw);
    return ((v << 1) | {63'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// rtl/wshb_if.sv - Wishbone classic bus signals with master and slave views
interface wshb_if #(
  parameter int DATA_BYTES = 2,
  parameter int ADDR_WIDTH = 32
);
  localparam int DW = 8 * DATA_BYTES;

  logic [ADDR_WIDTH-1:0] adr;
  logic [DW-1:0]         dat_ms;
  logic [DW-1:0]         dat_sm;
  logic                  we;
  logic [DATA_BYTES-1:0] sel;
  logic                  cyc;
  logic                  stb;
  logic                  ack;

  modport master (output adr, dat_ms, we, sel, cyc, stb, input dat_sm, ack);
  modport slave  (input adr, dat_ms, we, sel, cyc, stb, output dat_sm, ack);
endinterface

// File: rtl/wshb_pattern_gen.sv
// rtl/wshb_pattern_gen.sv - recomputes the test pattern for the current word; owns the LFSR
module wshb_pattern_gen
  import wshb_tester_pkg::*;
#(
  parameter int          DATA_BYTES = 2,
  parameter int          ADDR_WIDTH = 32,
  parameter int          CW         = 11,
  parameter logic [63:0] LFSR_SEED  = 64'hACE1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  mode_t                   mode,
  input  logic [CW-1:0]           idx,
  input  logic [ADDR_WIDTH-1:0]   adr,
  input  logic                    step,
  input  logic                    restart,
  output logic [8*DATA_BYTES-1:0] pattern
);
  localparam int DW = 8 * DATA_BYTES;

  logic [DW-1:0] lfsr_q, lfsr_d, lfsr_first;
  logic [31:0]   walk_sh;

  // Word 0 of each phase is the seed stepped once, so both phases line up word for word.
  assign lfsr_first = DW'(lfsr_next(64'(LFSR_SEED[DW-1:0]), DW));
  assign walk_sh    = 32'(idx) % 32'(DW);

  always_comb begin
    lfsr_d = lfsr_q;
    if (restart) lfsr_d = lfsr_first;
    else if (step) lfsr_d = DW'(lfsr_next(64'(lfsr_q), DW));
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= lfsr_first;
    else       lfsr_q <= lfsr_d;
  end

  always_comb begin
    pattern = '0;
    case (mode)
      MODE_ADDR:  pattern = DW'(adr);
      MODE_LFSR:  pattern = lfsr_q;
      MODE_WALK:  pattern = DW'(1) << walk_sh;
      MODE_NADDR: pattern = ~DW'(adr);
      default:    pattern = '0;
    endcase
  end
endmodule

// File: rtl/wshb_mem_tester.sv
// rtl/wshb_mem_tester.sv - self-checking Wishbone classic master: write pattern, read back, compare
module wshb_mem_tester
  import wshb_tester_pkg::*;
#(
  parameter int          DATA_BYTES = 2,
  parameter int          ADDR_WIDTH = 32,
  parameter int          N_WORDS    = 1024,
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter logic [63:0] LFSR_SEED  = 64'hACE1,
  parameter int          TIMEOUT    = 1023,
  localparam int         CW         = $clog2(N_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CW-1:0]         err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  wshb_if.master                wb
);
  localparam int DW = 8 * DATA_BYTES;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                state_q, state_d;
  mode_t                 mode_q, mode_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [TW-1:0]         wait_q, wait_d;
  logic [CW-1:0]         err_q, err_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;
  logic                  to_q, to_d;
  logic                  pass_q, pass_d;

  logic                  active, last, step, restart, mismatch;
  logic [ADDR_WIDTH-1:0] cur_adr;
  logic [DW-1:0]         pattern;

  assign active   = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
  assign last     = (idx_q == CW'(N_WORDS - 1));
  assign cur_adr  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(DATA_BYTES);
  assign mismatch = (wb.dat_sm != pattern);

  wshb_pattern_gen #(
    .DATA_BYTES(DATA_BYTES),
    .ADDR_WIDTH(ADDR_WIDTH),
    .CW        (CW),
    .LFSR_SEED (LFSR_SEED)
  ) u_pattern (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode_q),
    .idx    (idx_q),
    .adr    (cur_adr),
    .step   (step),
    .restart(restart),
    .pattern(pattern)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    err_d   = err_q;
    first_d = first_q;
    to_d    = to_q;
    pass_d  = pass_q;
    step    = 1'b0;
    restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode_t'(mode);
          idx_d   = '0;
          wait_d  = '0;
          err_d   = '0;
          first_d = '0;
          to_d    = 1'b0;
          pass_d  = 1'b0;
          restart = 1'b1;
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ, ST_RD_REQ: begin
        if (wb.ack) begin
          step   = 1'b1;
          wait_d = '0;
          if (state_q == ST_RD_REQ && mismatch) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (err_q == '0) first_d = cur_adr;
          end
          if (!last) begin
            idx_d = idx_q + 1'b1;
          end else if (state_q == ST_WR_REQ) begin
            // The restart overrides the step so the read phase replays from word 0.
            idx_d   = '0;
            restart = 1'b1;
            state_d = ST_RD_REQ;
          end else begin
            pass_d  = (err_d == '0);
            state_d = ST_FINISH;
          end
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          pass_d  = 1'b0;
          state_d = ST_FINISH;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ADDR;
      idx_q   <= '0;
      wait_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
      to_q    <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      first_q <= first_d;
      to_q    <= to_d;
      pass_q  <= pass_d;
    end
  end

  assign wb.cyc         = active;
  assign wb.stb         = active;
  assign wb.we          = (state_q == ST_WR_REQ);
  assign wb.sel         = '1;
  assign wb.adr         = active ? cur_adr : '0;
  assign wb.dat_ms      = (state_q == ST_WR_REQ) ? pattern : '0;
  assign busy           = active;
  assign done           = (state_q == ST_FINISH);
  assign pass           = pass_q;
  assign timeout        = to_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
endmodule
